// File: rtl/ara_pkg.sv
// Shared types for the lane's serial divide path.
package ara_pkg;

    // Serial divide operation; also used by the SIMD divide front-end.
    typedef enum logic [1:0] {
        SERDIV_DIVU = 2'b00,
        SERDIV_DIV  = 2'b01,
        SERDIV_REMU = 2'b10,
        SERDIV_REM  = 2'b11
    } serdiv_op_e;

    // Signed variants take absolute values and fix the sign afterwards.
    function automatic logic serdiv_is_signed(serdiv_op_e op);
        return (op == SERDIV_DIV) || (op == SERDIV_REM);
    endfunction

    // Remainder variants return the remainder instead of the quotient.
    function automatic logic serdiv_is_rem(serdiv_op_e op);
        return (op == SERDIV_REMU) || (op == SERDIV_REM);
    endfunction

endpackage

// File: rtl/ara_serdiv_if.sv
// Request/result bundle between the SIMD divide front-end and ara_serdiv.
//
// Handshake: a request transfers on a clock edge where in_vld_i and in_rdy_o
// are both high; a result transfers on an edge where out_vld_o and out_rdy_i
// are both high. A raised valid keeps its payload stable until it transfers
// (or flush_i aborts it); ready never depends combinationally on in_vld_i.
interface ara_serdiv_if
    import ara_pkg::*;
#(
    parameter int unsigned WIDTH = 64
);
    logic [WIDTH-1:0] op_a_i;
    logic [WIDTH-1:0] op_b_i;
    serdiv_op_e       opcode_i;
    logic             in_vld_i;
    logic             in_rdy_o;
    logic             flush_i;
    logic             out_vld_o;
    logic             out_rdy_i;
    logic [WIDTH-1:0] res_o;

    modport master (
        output op_a_i, op_b_i, opcode_i, in_vld_i, flush_i, out_rdy_i,
        input  in_rdy_o, out_vld_o, res_o
    );

    modport slave (
        input  op_a_i, op_b_i, opcode_i, in_vld_i, flush_i, out_rdy_i,
        output in_rdy_o, out_vld_o, res_o
    );
endinterface

// File: rtl/ara_serdiv.sv
// Radix-2 restoring serial divider: one quotient bit per cycle, MSB first,
// RISC-V V divu/div/remu/rem semantics including divide-by-zero results.
module ara_serdiv
    import ara_pkg::*;
#(
    parameter int unsigned WIDTH            = 64,
    parameter bit          STABLE_HANDSHAKE = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    ara_serdiv_if.slave       div_if,
    output logic [1:0]        state_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FINISH = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    serdiv_op_e       op_q, op_d;
    logic             q_sign_q, q_sign_d;
    logic             r_sign_q, r_sign_d;
    logic             div_zero_q, div_zero_d;

    logic             sign_a, sign_b;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   partial, diff;
    logic             borrow;
    logic             in_rdy, accept;
    logic [WIDTH-1:0] res;

    // Sign and magnitude of the incoming operands (raw for unsigned ops)
    always_comb begin
        sign_a = serdiv_is_signed(div_if.opcode_i) & div_if.op_a_i[WIDTH-1];
        sign_b = serdiv_is_signed(div_if.opcode_i) & div_if.op_b_i[WIDTH-1];
        abs_a  = sign_a ? (WIDTH'(0) - div_if.op_a_i) : div_if.op_a_i;
        abs_b  = sign_b ? (WIDTH'(0) - div_if.op_b_i) : div_if.op_b_i;
    end

    // One restoring step; the partial remainder keeps its top bit so divisors
    // above 2^(WIDTH-1) still compare correctly, and the borrow is the compare
    always_comb begin
        partial = {rem_q, quot_q[WIDTH-1]};
        diff    = partial - {1'b0, div_q};
        borrow  = diff[WIDTH];
    end

    // Request acceptance; a flush blocks any new request in its cycle
    always_comb begin
        in_rdy = 1'b0;
        case (state_q)
            IDLE:    in_rdy = 1'b1;
            FINISH:  in_rdy = (STABLE_HANDSHAKE == 1'b0) && div_if.out_rdy_i;
            default: in_rdy = 1'b0;
        endcase
        if (div_if.flush_i) begin
            in_rdy = 1'b0;
        end
        accept = div_if.in_vld_i & in_rdy;
    end

    // Next state and datapath: shift during DIVIDE, load on accept, flush wins
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        div_d      = div_q;
        a_raw_d    = a_raw_q;
        op_d       = op_q;
        q_sign_d   = q_sign_q;
        r_sign_d   = r_sign_q;
        div_zero_d = div_zero_q;

        case (state_q)
            DIVIDE: begin
                quot_d = {quot_q[WIDTH-2:0], ~borrow};
                rem_d  = borrow ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
                if (cnt_q == '0) begin
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FINISH: begin
                if (div_if.out_rdy_i) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        if (accept) begin
            state_d    = DIVIDE;
            cnt_d      = CW'(WIDTH - 1);
            quot_d     = abs_a;
            rem_d      = '0;
            div_d      = abs_b;
            a_raw_d    = div_if.op_a_i;
            op_d       = div_if.opcode_i;
            q_sign_d   = sign_a ^ sign_b;
            r_sign_d   = sign_a;
            div_zero_d = (div_if.op_b_i == '0);
        end

        if (div_if.flush_i) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            div_q      <= '0;
            a_raw_q    <= '0;
            op_q       <= SERDIV_DIVU;
            q_sign_q   <= 1'b0;
            r_sign_q   <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            div_q      <= div_d;
            a_raw_q    <= a_raw_d;
            op_q       <= op_d;
            q_sign_q   <= q_sign_d;
            r_sign_q   <= r_sign_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Result selection and sign fix-up; zero outside FINISH
    always_comb begin
        res = '0;
        if (state_q == FINISH) begin
            case (op_q)
                SERDIV_DIVU: res = quot_q;
                SERDIV_DIV:  res = q_sign_q ? (WIDTH'(0) - quot_q) : quot_q;
                SERDIV_REMU: res = rem_q;
                SERDIV_REM:  res = r_sign_q ? (WIDTH'(0) - rem_q) : rem_q;
                default:     res = '0;
            endcase
            if (div_zero_q) begin
                res = serdiv_is_rem(op_q) ? a_raw_q : '1;
            end
        end
    end

    assign div_if.in_rdy_o  = in_rdy;
    assign div_if.out_vld_o = (state_q == FINISH);
    assign div_if.res_o     = res;
    assign state_o          = state_q;

endmodule

// File: tb/tb_ara_serdiv.sv
// Bench for ara_serdiv: two instances (stable and fast handshake) share one
// stimulus stream; a per-lane arithmetic model predicts valid/ready/result.
module tb_ara_serdiv;
  import ara_pkg::*;

  localparam int W = 64;
  localparam int LAT = W + 1;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared stimulus ----------------
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  serdiv_op_e opcode = SERDIV_DIVU;
  logic in_vld = 1'b0;
  logic flush = 1'b0;
  logic out_rdy = 1'b0;

  ara_serdiv_if #(.WIDTH(W)) if_s ();
  ara_serdiv_if #(.WIDTH(W)) if_f ();

  assign if_s.op_a_i = op_a;
  assign if_s.op_b_i = op_b;
  assign if_s.opcode_i = opcode;
  assign if_s.in_vld_i = in_vld;
  assign if_s.flush_i = flush;
  assign if_s.out_rdy_i = out_rdy;
  assign if_f.op_a_i = op_a;
  assign if_f.op_b_i = op_b;
  assign if_f.opcode_i = opcode;
  assign if_f.in_vld_i = in_vld;
  assign if_f.flush_i = flush;
  assign if_f.out_rdy_i = out_rdy;

  logic [1:0] dbg_s, dbg_f;

  ara_serdiv #(.WIDTH(W), .STABLE_HANDSHAKE(1'b1)) u_dut_s (
    .clk_i(clk), .rst_ni(rst_n), .div_if(if_s), .state_o(dbg_s)
  );
  ara_serdiv #(.WIDTH(W), .STABLE_HANDSHAKE(1'b0)) u_dut_f (
    .clk_i(clk), .rst_ni(rst_n), .div_if(if_f), .state_o(dbg_f)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RISC-V V division semantics in plain arithmetic
  function automatic logic [W-1:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input serdiv_op_e op);
    logic want_rem;
    want_rem = (op == SERDIV_REMU) || (op == SERDIV_REM);
    if (b == '0) return want_rem ? a : '1;
    case (op)
      SERDIV_DIVU: return a / b;
      SERDIV_REMU: return a % b;
      SERDIV_DIV: begin
        if (a == MIN_NEG && b == '1) return a;
        return $signed(a) / $signed(b);
      end
      default: begin
        if (a == MIN_NEG && b == '1) return '0;
        return $signed(a) % $signed(b);
      end
    endcase
  endfunction

  // Per-lane model: outstanding flag, expected result, cycle the result is due
  logic [W-1:0] exp_q [$];
  bit pend [2];
  logic [W-1:0] exp_res [2];
  longint due [2];

  task automatic lane_step(input int i, input logic vld, input logic irdy, input logic [W-1:0] res);
    string p;
    bit stable;
    bit exp_vld;
    bit exp_irdy;
    p = (i == 0) ? "stable" : "fast";
    stable = (i == 0);
    exp_vld = pend[i] && (cyc >= due[i]);
    exp_irdy = !flush && (!pend[i] || (exp_vld && !stable && out_rdy));
    chk({p, " out_vld"}, vld, exp_vld);
    chk({p, " in_rdy"}, irdy, exp_irdy);
    if (exp_vld) chk({p, " res"}, res, exp_res[i]);
    if (flush) begin
      pend[i] = 1'b0;
    end else begin
      if (exp_vld && out_rdy) pend[i] = 1'b0;
      if (in_vld && exp_irdy) begin
        pend[i] = 1'b1;
        exp_res[i] = ref_res(op_a, op_b, opcode);
        due[i] = cyc + LAT;
        if (i == 0) exp_q.push_back(exp_res[i]);
      end
    end
  endtask

  // Compare process: checks both lanes on every falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset stable out_vld", if_s.out_vld_o, 1'b0);
        chk("reset stable res", if_s.res_o, '0);
        chk("reset stable in_rdy", if_s.in_rdy_o, 1'b1);
        chk("reset fast out_vld", if_f.out_vld_o, 1'b0);
        chk("reset fast res", if_f.res_o, '0);
        pend[0] = 1'b0;
        pend[1] = 1'b0;
      end else begin
        lane_step(0, if_s.out_vld_o, if_s.in_rdy_o, if_s.res_o);
        lane_step(1, if_f.out_vld_o, if_f.in_rdy_o, if_f.res_o);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the stable lane's result; returns cycles since t0 or -1
  task automatic wait_result(input longint t0, output longint lat);
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (if_s.out_vld_o) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  // Directed transaction; caller is at posedge+1 with both lanes idle
  task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b, input serdiv_op_e op,
                        input logic [W-1:0] exp, input string name, input bit hold);
    longint t0;
    longint lat;
    op_a = a;
    op_b = b;
    opcode = op;
    in_vld = 1'b1;
    out_rdy = !hold;
    @(negedge clk);
    t0 = cyc;
    chk({name, " accepted"}, if_s.in_rdy_o, 1'b1);
    step();
    in_vld = 1'b0;
    op_a = {$urandom, $urandom};
    op_b = {$urandom, $urandom};
    wait_result(t0, lat);
    chk({name, " latency"}, 64'(lat), 64'(LAT));
    chk({name, " res"}, if_s.res_o, exp);
    chk({name, " fast res"}, if_f.res_o, exp);
    if (hold) begin
      for (int k = 0; k < 10; k++) begin
        step();
        @(negedge clk);
        chk({name, " held vld"}, if_s.out_vld_o, 1'b1);
        chk({name, " held res"}, if_s.res_o, exp);
        chk({name, " held in_rdy"}, if_s.in_rdy_o, 1'b0);
      end
      step();
      out_rdy = 1'b1;
      @(negedge clk);
      chk({name, " stable in_rdy at out hs"}, if_s.in_rdy_o, 1'b0);
      chk({name, " fast in_rdy at out hs"}, if_f.in_rdy_o, 1'b1);
      step();
      @(negedge clk);
      chk({name, " stable in_rdy after hs"}, if_s.in_rdy_o, 1'b1);
    end
    step();
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return MIN_NEG;
      2: return '1;
      3: return 64'($urandom_range(0, 50));
      4: return -64'($urandom_range(1, 50));
      5: return {32'h0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    longint t0;
    longint t1;
    longint lat;
    bit seen;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // Arithmetic cases with hand-computed results
    do_txn(64'd100, 64'd7, SERDIV_DIVU, 64'd14, "divu 100/7", 1'b0);
    do_txn(64'd100, 64'd7, SERDIV_REMU, 64'd2, "remu 100%7", 1'b0);
    do_txn(-64'd100, 64'd7, SERDIV_DIV, 64'hFFFF_FFFF_FFFF_FFF2, "div -100/7", 1'b0);
    do_txn(-64'd100, 64'd7, SERDIV_REM, 64'hFFFF_FFFF_FFFF_FFFE, "rem -100%7", 1'b0);
    do_txn(64'd100, -64'd7, SERDIV_REM, 64'd2, "rem 100%-7", 1'b0);
    do_txn(64'd5, 64'd0, SERDIV_DIV, '1, "div by 0", 1'b0);
    do_txn(64'd5, 64'd0, SERDIV_DIVU, '1, "divu by 0", 1'b0);
    do_txn(64'h1234, 64'd0, SERDIV_REM, 64'h1234, "rem by 0", 1'b0);
    do_txn(MIN_NEG, '1, SERDIV_DIV, MIN_NEG, "div overflow", 1'b0);
    do_txn(MIN_NEG, '1, SERDIV_REM, 64'd0, "rem overflow", 1'b0);
    do_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, SERDIV_REMU,
           64'h7FFF_FFFF_FFFF_FFFE, "remu big divisor", 1'b0);

    // Backpressure: result held for 10 cycles
    do_txn(64'd1000, 64'd9, SERDIV_DIVU, 64'd111, "backpressure", 1'b1);

    // Back-to-back on the fast lane: new request offered in the result cycle
    op_a = 64'd1000;
    op_b = 64'd10;
    opcode = SERDIV_DIVU;
    in_vld = 1'b1;
    out_rdy = 1'b1;
    @(negedge clk);
    t0 = cyc;
    step();
    in_vld = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    #1;
    op_a = 64'd779;
    op_b = 64'd3;
    opcode = SERDIV_REMU;
    in_vld = 1'b1;
    @(negedge clk);
    t1 = cyc;
    chk("b2b first latency", 64'(t1 - t0), 64'(LAT));
    chk("b2b first vld", if_f.out_vld_o, 1'b1);
    chk("b2b first res", if_f.res_o, 64'd100);
    chk("b2b fast in_rdy", if_f.in_rdy_o, 1'b1);
    step();
    in_vld = 1'b0;
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (if_f.out_vld_o) begin
        lat = cyc - t1;
        break;
      end
    end
    chk("b2b second latency", 64'(lat), 64'(LAT));
    chk("b2b second res", if_f.res_o, 64'd2);
    step();

    // Flush at T+30: no result, ready again at T+31
    op_a = 64'd500;
    op_b = 64'd5;
    opcode = SERDIV_DIV;
    in_vld = 1'b1;
    @(negedge clk);
    t0 = cyc;
    step();
    in_vld = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush cycle offset", 64'(cyc - t0), 64'd30);
    chk("flush blocks in_rdy", if_s.in_rdy_o, 1'b0);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("in_rdy after flush stable", if_s.in_rdy_o, 1'b1);
    chk("in_rdy after flush fast", if_f.in_rdy_o, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      seen = seen | if_s.out_vld_o | if_f.out_vld_o;
    end
    chk("no result after flush", seen, 1'b0);
    step();
    do_txn(64'd42, 64'd6, SERDIV_DIVU, 64'd7, "after flush 42/6", 1'b0);

    // Asynchronous reset in the middle of DIVIDE
    op_a = 64'd12345;
    op_b = 64'd11;
    opcode = SERDIV_DIVU;
    in_vld = 1'b1;
    step();
    in_vld = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset out_vld", if_s.out_vld_o, 1'b0);
    chk("async reset res", if_s.res_o, '0);
    chk("async reset in_rdy", if_s.in_rdy_o, 1'b1);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    step();
    do_txn(64'd9, 64'd3, SERDIV_DIVU, 64'd3, "after reset 9/3", 1'b0);

    // Randomized traffic with backpressure and occasional flushes
    for (int n = 0; n < 3000; n++) begin
      in_vld = 1'($urandom_range(0, 1));
      op_a = rnd_operand();
      op_b = rnd_operand();
      opcode = serdiv_op_e'($urandom_range(0, 3));
      out_rdy = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 99) == 0);
      step();
    end
    in_vld = 1'b0;
    flush = 1'b0;
    out_rdy = 1'b1;
    repeat (LAT + 5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
